// File: rtl/addsub_arbiter_if.sv
// Request/unit/response bundle for addsub_arbiter.
// rsp_z exists only when ADDSUB_ZERO_FLAG_EN is defined.
interface addsub_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic       req0_m;
  logic       req1_m;
  logic [3:0] req0_a;
  logic [3:0] req1_a;
  logic [3:0] req0_b;
  logic [3:0] req1_b;
  logic       au_m;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic [3:0] au_s;
  logic       au_c;
  logic       au_v;
  logic       rsp_valid;
  logic       rsp_id;
  logic [3:0] rsp_s;
  logic       rsp_c;
  logic       rsp_v;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic       rsp_z;
`endif

  modport slave (
    input  req0_valid, req1_valid, req0_m, req1_m,
    input  req0_a, req1_a, req0_b, req1_b,
    input  au_s, au_c, au_v,
    output req0_ready, req1_ready,
    output au_m, au_a, au_b,
    output rsp_valid, rsp_id, rsp_s, rsp_c, rsp_v
`ifdef ADDSUB_ZERO_FLAG_EN
    , output rsp_z
`endif
  );

  modport master (
    output req0_valid, req1_valid, req0_m, req1_m,
    output req0_a, req1_a, req0_b, req1_b,
    output au_s, au_c, au_v,
    input  req0_ready, req1_ready,
    input  au_m, au_a, au_b,
    input  rsp_valid, rsp_id, rsp_s, rsp_c, rsp_v
`ifdef ADDSUB_ZERO_FLAG_EN
    , input rsp_z
`endif
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared 4-bit adder-subtractor.
// Optional zero flag on the response bus: define ADDSUB_ZERO_FLAG_EN.
module addsub_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  addsub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  localparam logic [3:0] LP_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic       r_ptr;
  logic [3:0] r_cnt;
  logic       r_owner;
  logic       r_au_m;
  logic [3:0] r_au_a;
  logic [3:0] r_au_b;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [3:0] r_rsp_s;
  logic       r_rsp_c;
  logic       r_rsp_v;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic       r_rsp_z;
`endif

  logic w_grant0;
  logic w_grant1;
  logic w_idle;

  always_comb begin
    w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_ptr);
    w_grant1 = bus.req1_valid & (~bus.req0_valid |  r_ptr);
    // Ready must stay low while reset is held even though the state already reads IDLE.
    w_idle   = rst_n & (r_state == S_IDLE);
  end

  assign bus.req0_ready = w_idle & w_grant0;
  assign bus.req1_ready = w_idle & w_grant1;
  assign bus.au_m       = r_au_m;
  assign bus.au_a       = r_au_a;
  assign bus.au_b       = r_au_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_s      = r_rsp_s;
  assign bus.rsp_c      = r_rsp_c;
  assign bus.rsp_v      = r_rsp_v;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign bus.rsp_z      = r_rsp_z;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_au_m      <= 1'b0;
      r_au_a      <= '0;
      r_au_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_s     <= '0;
      r_rsp_c     <= 1'b0;
      r_rsp_v     <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      r_rsp_z     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_grant0 | w_grant1) begin
            r_au_m  <= w_grant1 ? bus.req1_m : bus.req0_m;
            r_au_a  <= w_grant1 ? bus.req1_a : bus.req0_a;
            r_au_b  <= w_grant1 ? bus.req1_b : bus.req0_b;
            // Owner is held privately so rsp_id keeps the previous result's tag until capture.
            r_owner <= w_grant1;
            r_ptr   <= w_grant0;
            r_cnt   <= LP_LOAD;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_s     <= bus.au_s;
            r_rsp_c     <= bus.au_c;
            r_rsp_v     <= bus.au_v;
`ifdef ADDSUB_ZERO_FLAG_EN
            r_rsp_z     <= (bus.au_s == 4'b0000);
`endif
            r_rsp_id    <= r_owner;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
